// File: rtl/shift_unit_seq.sv
// shift_unit_seq: sequential shifter, one bit position per clock.
// Operations: sll, srl, sra, ror. The 2-bit operation select port is
// named shift_type because "type" is a reserved word in SystemVerilog.
// Optional feature macro: SHIFT_UNIT_CARRY_EN adds the 'carry' output
// holding the last bit shifted (or rotated) out.
module shift_unit_seq #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   data,
  input  logic [SHAMT_W-1:0] num,
  input  logic [1:0]         shift_type,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
`ifdef SHIFT_UNIT_CARRY_EN
  ,
  output logic               carry
`endif
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [WIDTH-1:0]   work;
  logic [WIDTH-1:0]   work_shifted_c;
  logic [SHAMT_W-1:0] cnt;
  logic [1:0]         type_q;
  logic               accept_c;
  logic               last_shift_c;

  // One-bit shift of the working register per the latched operation
  always_comb begin
    work_shifted_c = work;
    case (type_q)
      OP_SLL:  work_shifted_c = {work[WIDTH-2:0], 1'b0};
      OP_SRL:  work_shifted_c = {1'b0, work[WIDTH-1:1]};
      OP_SRA:  work_shifted_c = {work[WIDTH-1], work[WIDTH-1:1]};
      OP_ROR:  work_shifted_c = {work[0], work[WIDTH-1:1]};
      default: work_shifted_c = work;
    endcase
  end

`ifdef SHIFT_UNIT_CARRY_EN
  logic shift_out_c;

  // Bit leaving the register on this shift (MSB for sll, LSB otherwise)
  always_comb begin
    shift_out_c = 1'b0;
    if (type_q == OP_SLL) begin
      shift_out_c = work[WIDTH-1];
    end else begin
      shift_out_c = work[0];
    end
  end
`endif

  // Next-state and control decode; start is only honoured outside SHIFT
  always_comb begin
    next_state   = state;
    accept_c     = 1'b0;
    last_shift_c = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept_c   = 1'b1;
          next_state = (num != '0) ? SHIFT : DONE;
        end else begin
          next_state = IDLE;
        end
      end
      SHIFT: begin
        if (cnt == SHAMT_W'(1)) begin
          last_shift_c = 1'b1;
          next_state   = DONE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register with registered status flags derived from next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state == SHIFT);
      done  <= (next_state == DONE);
    end
  end

  // Datapath: load on accept, shift while busy, publish result at DONE entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      work   <= '0;
      cnt    <= '0;
      type_q <= 2'b00;
      result <= '0;
`ifdef SHIFT_UNIT_CARRY_EN
      carry  <= 1'b0;
`endif
    end else if (accept_c) begin
      work   <= data;
      cnt    <= num;
      type_q <= shift_type;
      if (num == '0) begin
        result <= data;
`ifdef SHIFT_UNIT_CARRY_EN
        carry  <= 1'b0;
`endif
      end
    end else if (state == SHIFT) begin
      work <= work_shifted_c;
      cnt  <= cnt - SHAMT_W'(1);
      if (last_shift_c) begin
        result <= work_shifted_c;
`ifdef SHIFT_UNIT_CARRY_EN
        carry  <= shift_out_c;
`endif
      end
    end
  end

endmodule
